// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the round engine.
// S-boxes are computed from the field inverse and affine map rather than tabulated.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_state_e;

    function automatic int aes_nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as SubBytes requires.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t r;
        byte_t p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic byte_t sbox(input byte_t a);
        byte_t b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic byte_t inv_sbox(input byte_t s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic word_t mix_column(input word_t col, input logic inv);
        byte_t a [4];
        word_t res;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            if (inv)
                res[31-8*i -: 8] = gmul(a[i], 8'h0e) ^ gmul(a[(i+1)%4], 8'h0b) ^
                                   gmul(a[(i+2)%4], 8'h0d) ^ gmul(a[(i+3)%4], 8'h09);
            else
                res[31-8*i -: 8] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03) ^
                                   a[(i+2)%4] ^ a[(i+3)%4];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: (Inv)SubBytes, (Inv)ShiftRows, optional (Inv)MixColumns, AddRoundKey.
// Decrypt follows the equivalent inverse cipher, so the stage order is identical in both modes.
module aes_round_dp
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t key,
    input  logic   inv,
    input  logic   last,
    output block_t result
);

    byte_t  sub [16];
    block_t shifted;
    block_t mixed;

    for (genvar b = 0; b < 16; b++) begin : g_sub
        assign sub[b] = inv ? inv_sbox(state[127-8*b -: 8]) : sbox(state[127-8*b -: 8]);
    end

    // Byte index is 4*column + row; row r rotates left by r, or right by r when inverting.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted[127-8*(4*c+r) -: 8] = inv ? sub[4*((c+4-r)%4)+r] : sub[4*((c+r)%4)+r];
        end
        assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32], inv);
    end

    assign result = (last ? shifted : mixed) ^ key;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES engine: round 0 ARK on accept, then one full round per clock until round NR.
// Defining AES_ROUND_ENGINE_CTR_EN adds a 128-bit counter (ctr_load/ctr_init) and CTR-mode output.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_dec,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       rk_idx,
    input  logic [127:0]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef AES_ROUND_ENGINE_CTR_EN
    ,
    input  logic             ctr_load,
    input  logic [127:0]     ctr_init
`endif
);

    localparam int         NR     = aes_nr(KEY_BITS);
    localparam logic [3:0] NR_IDX = 4'(NR);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
    end

    fsm_state_e       state_q, state_d;
    logic [3:0]       round_q;
    block_t           blk_q, out_q, rnd_out, start_blk, pad;
    logic             dec_q, eff_dec, accept, last;
    logic [TAG_W-1:0] tag_q;

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = (state_q == RUN) && (round_q == NR_IDX);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;
    assign out_tag   = tag_q;

    // Outside RUN the live mode picks the round-0 key for a block about to be accepted.
    assign rk_idx = (state_q == RUN) ? (dec_q ? NR_IDX - round_q : round_q)
                                     : (eff_dec ? NR_IDX : 4'd0);

`ifdef AES_ROUND_ENGINE_CTR_EN
    block_t ctr_q, ctr_src, pad_q;
    logic   unused_in_dec;

    assign unused_in_dec = in_dec;
    assign ctr_src       = ctr_load ? ctr_init : ctr_q;
    assign start_blk     = ctr_src;
    assign eff_dec       = 1'b0;
    assign pad           = pad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
            pad_q <= '0;
        end else if (accept) begin
            ctr_q <= {ctr_src[127:32], ctr_src[31:0] + 32'd1};
            pad_q <= in_data;
        end else if (ctr_load) begin
            ctr_q <= ctr_init;
        end
    end
`else
    assign start_blk = in_data;
    assign eff_dec   = in_dec;
    assign pad       = '0;
`endif

    aes_round_dp u_dp (
        .state  (blk_q),
        .key    (rk_data),
        .inv    (dec_q),
        .last   (last),
        .result (rnd_out)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: rst is synchronous, so it is tested inside the clocked branch, not in the sensitivity list.
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
            out_q   <= '0;
            tag_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                blk_q   <= start_blk ^ rk_data;
                dec_q   <= eff_dec;
                tag_q   <= in_tag;
                round_q <= 4'd1;
            end else if (state_q == RUN) begin
                blk_q <= rnd_out;
                if (last) begin
                    out_q   <= rnd_out ^ pad;
                    round_q <= '0;
                end else begin
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors for 128/192/256, handshake, reset and key-index checks.
// With AES_ROUND_ENGINE_CTR_EN defined the plain-cipher tests are replaced by CTR-mode tests.
module tb_aes_round_engine;

    typedef logic [127:0] rk_arr_t [16];
    typedef struct {
        logic [127:0] din;
        logic         dec;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, in_ready, in_dec = 1'b0, out_valid, out_ready = 1'b0;
    logic [127:0] in_data = '0, rk_data, out_data;
    logic [3:0]   in_tag = '0, rk_idx, out_tag;

    logic         in_valid_s = 1'b0, out_ready_s = 1'b0;
    logic         in_ready_128, out_valid_128, in_ready_192, out_valid_192;
    logic [3:0]   rk_idx_128, rk_idx_192, out_tag_128, out_tag_192;
    logic [127:0] out_data_128, out_data_192;

    rk_arr_t enc_rk, dec_rk, rk128, rk192;
    logic    ks_dec = 1'b0;

    assign rk_data = ks_dec ? dec_rk[rk_idx] : enc_rk[rk_idx];

`ifdef AES_ROUND_ENGINE_CTR_EN
    logic         ctr_load = 1'b0;
    logic [127:0] ctr_init = '0;
`endif

    aes_round_engine #(.KEY_BITS(256), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dec(in_dec), .in_tag(in_tag), .rk_idx(rk_idx), .rk_data(rk_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef AES_ROUND_ENGINE_CTR_EN
        , .ctr_load(ctr_load), .ctr_init(ctr_init)
`endif
    );

    aes_round_engine #(.KEY_BITS(128), .TAG_W(4)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_128), .in_data(in_data),
        .in_dec(1'b0), .in_tag(in_tag), .rk_idx(rk_idx_128), .rk_data(rk128[rk_idx_128]),
        .out_valid(out_valid_128), .out_ready(out_ready_s), .out_data(out_data_128), .out_tag(out_tag_128)
`ifdef AES_ROUND_ENGINE_CTR_EN
        , .ctr_load(1'b0), .ctr_init(128'h0)
`endif
    );

    aes_round_engine #(.KEY_BITS(192), .TAG_W(4)) u_dut192 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_192), .in_data(in_data),
        .in_dec(1'b0), .in_tag(in_tag), .rk_idx(rk_idx_192), .rk_data(rk192[rk_idx_192]),
        .out_valid(out_valid_192), .out_ready(out_ready_s), .out_data(out_data_192), .out_tag(out_tag_192)
`ifdef AES_ROUND_ENGINE_CTR_EN
        , .ctr_load(1'b0), .ctr_init(128'h0)
`endif
    );

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] tb_sub(input logic [7:0] a);
        return sbox_flat[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [31:0] tb_subw(input logic [31:0] w);
        return {tb_sub(w[31:24]), tb_sub(w[23:16]), tb_sub(w[15:8]), tb_sub(w[7:0])};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic void expand(input logic [255:0] key, input int nk, output rk_arr_t rk);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = tb_subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = tb_subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // InvMixColumns on a round key, as the key store holds it for the equivalent inverse cipher.
    function automatic logic [127:0] tb_imc(input logic [127:0] k);
        logic [127:0] res;
        logic [7:0] a [4];
        logic [7:0] m2, m4, m8, x9, xb, xd, xe;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
            for (int j = 0; j < 4; j++) begin
                res[127-32*c-8*j -: 8] = '0;
                for (int m = 0; m < 4; m++) begin
                    m2 = xt(a[(j+m)%4]); m4 = xt(m2); m8 = xt(m4);
                    x9 = m8 ^ a[(j+m)%4]; xb = m8 ^ m2 ^ a[(j+m)%4]; xd = m8 ^ m4 ^ a[(j+m)%4]; xe = m8 ^ m4 ^ m2;
                    res[127-32*c-8*j -: 8] ^= (m == 0) ? xe : (m == 1) ? xb : (m == 2) ? xd : x9;
                end
            end
        end
        return res;
    endfunction

`ifdef AES_ROUND_ENGINE_CTR_EN
    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input rk_arr_t rk, input int nr);
        logic [127:0] s, t;
        logic [7:0] a [4];
        s = pt ^ rk[0];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    t[127-8*(4*c+j) -: 8] = tb_sub(s[127-8*(4*((c+j)%4)+j) -: 8]);
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = t[127-32*c-8*j -: 8];
                    for (int j = 0; j < 4; j++)
                        t[127-32*c-8*j -: 8] = xt(a[j]) ^ xt(a[(j+1)%4]) ^ a[(j+1)%4] ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            s = t ^ rk[r];
        end
        return s;
    endfunction
`endif

    function automatic logic [3:0] exp_idx(input logic dec, input int k);
        return dec ? 4'(14 - k) : 4'(k);
    endfunction

    // Called at a negedge with the block already driven; returns at the negedge where out_valid is seen.
    task automatic wait_result(input logic dec, output int lat, output int rk_bad);
        lat = 0;
        rk_bad = (rk_idx !== exp_idx(dec, 0)) ? 1 : 0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
`ifdef AES_ROUND_ENGINE_CTR_EN
        ctr_load = 1'b0;
`endif
        while (!out_valid && lat < 40) begin
            if (rk_idx !== exp_idx(dec, lat)) rk_bad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic drive(input logic [127:0] d, input logic dec, input logic [3:0] tag);
        in_valid = 1'b1; in_data = d; in_dec = dec; in_tag = tag; ks_dec = dec;
        #1;
    endtask

    vec_t vecs [3];
    int   lat, rk_bad, lat128, lat192, hold_bad, ready_bad;
    logic [127:0] held_d;
    logic [3:0]   held_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, enc_rk);
        dec_rk = enc_rk;
        for (int r = 1; r < 14; r++) dec_rk[r] = tb_imc(enc_rk[r]);
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, rk128);
        expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, rk192);

        vecs[0] = '{din: PT,    dec: 1'b0, tag: 4'h1, exp: CT256};
        vecs[1] = '{din: CT256, dec: 1'b1, tag: 4'h2, exp: PT};
        vecs[2] = '{din: CT256, dec: 1'b1, tag: 4'hf, exp: PT};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'h0);
        check("reset_in_ready", 128'(in_ready), 128'h1);
        check("reset_out_data", out_data, 128'h0);
        check("reset_out_tag", 128'(out_tag), 128'h0);
        check("reset_rk_idx", 128'(rk_idx), 128'h0);
        rst = 1'b0;

`ifndef AES_ROUND_ENGINE_CTR_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(vecs[i].din, vecs[i].dec, vecs[i].tag);
            wait_result(vecs[i].dec, lat, rk_bad);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 128'(out_tag), 128'(vecs[i].tag));
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd15);
            check($sformatf("vec%0d_rk_idx_seq", i), 128'(rk_bad), 128'd0);
            release_out();
        end
        check("idle_after_release", 128'(out_valid), 128'h0);

        // Stall in DONE, then accept the next block in the same cycle the result is taken.
        @(negedge clk);
        drive(PT, 1'b0, 4'h3);
        wait_result(1'b0, lat, rk_bad);
        check("hold_first_data", out_data, CT256);
        check("hold_first_tag", 128'(out_tag), 128'h3);
        held_d = out_data; held_t = out_tag; hold_bad = 0; ready_bad = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || out_data !== held_d || out_tag !== held_t) hold_bad++;
            if (in_ready !== 1'b0) ready_bad++;
        end
        check("hold_stable", 128'(hold_bad), 128'd0);
        check("hold_in_ready_low", 128'(ready_bad), 128'd0);
        out_ready = 1'b1;
        drive(PT, 1'b0, 4'h4);
        check("done_accept_in_ready", 128'(in_ready), 128'h1);
        wait_result(1'b0, lat, rk_bad);
        check("b2b_latency", 128'(lat), 128'd15);
        check("b2b_data", out_data, CT256);
        check("b2b_tag", 128'(out_tag), 128'h4);
        release_out();

        // Reset while round 7 is in flight.
        @(negedge clk);
        drive(PT, 1'b0, 4'h5);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 128'(out_valid), 128'h0);
        check("midrst_in_ready", 128'(in_ready), 128'h1);
        check("midrst_out_data", out_data, 128'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_no_output", 128'(out_valid), 128'h0);
        drive(PT, 1'b0, 4'h6);
        wait_result(1'b0, lat, rk_bad);
        check("postrst_data", out_data, CT256);
        check("postrst_tag", 128'(out_tag), 128'h6);
        release_out();

        // 128- and 192-bit key builds run side by side on the same plaintext.
        @(negedge clk);
        in_data = PT; in_tag = 4'h9; in_valid_s = 1'b1;
        @(posedge clk);
        lat = 1; lat128 = 0; lat192 = 0;
        @(negedge clk);
        in_valid_s = 1'b0;
        repeat (40) begin
            if (out_valid_128 && lat128 == 0) lat128 = lat;
            if (out_valid_192 && lat192 == 0) lat192 = lat;
            if (lat128 != 0 && lat192 != 0) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("k128_latency", 128'(lat128), 128'd11);
        check("k192_latency", 128'(lat192), 128'd13);
        check("k128_data", out_data_128, CT128);
        check("k192_data", out_data_192, CT192);
        check("k128_tag", 128'(out_tag_128), 128'h9);
        out_ready_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s = 1'b0;
`else
        // CTR: low counter word wraps between the two blocks; in_dec must be ignored.
        @(negedge clk);
        ctr_load = 1'b1;
        ctr_init = {96'h00112233445566778899aabb, 32'hffffffff};
        in_valid = 1'b1; in_data = PT; in_dec = 1'b1; in_tag = 4'h7; ks_dec = 1'b0;
        #1;
        wait_result(1'b0, lat, rk_bad);
        check("ctr1_data", out_data, ref_enc({96'h00112233445566778899aabb, 32'hffffffff}, enc_rk, 14) ^ PT);
        check("ctr1_latency", 128'(lat), 128'd15);
        check("ctr1_rk_idx_seq", 128'(rk_bad), 128'd0);
        check("ctr1_tag", 128'(out_tag), 128'h7);
        release_out();
        @(negedge clk);
        in_valid = 1'b1; in_data = 128'hdeadbeef0123456789abcdeffedcba98; in_dec = 1'b0; in_tag = 4'h8;
        #1;
        wait_result(1'b0, lat, rk_bad);
        check("ctr2_data", out_data, ref_enc({96'h00112233445566778899aabb, 32'h0}, enc_rk, 14)
                                     ^ 128'hdeadbeef0123456789abcdeffedcba98);
        check("ctr2_tag", 128'(out_tag), 128'h8);
        release_out();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES block-cipher engine: one round per clock, round counter FSM and valid/ready handshakes on both sides.
- Parametrised over key size (128/192/256), so round count is 10/12/14.
- Per-block encrypt/decrypt select; decrypt uses the equivalent inverse cipher.
- Sits between the CTR datapath front end and the key-schedule store; round keys are fetched from the store by index each cycle.

Parameters:
- KEY_BITS, 256, key size in bits; legal values 128, 192, 256. Any other value is an elaboration error.
- NR, derived (KEY_BITS/32 + 6), number of rounds; localparam, not overridable.
- TAG_W, 4, width of the opaque tag carried alongside each block.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  engine can accept a block.
- in_data  in  128  plaintext (enc) or ciphertext (dec).
- in_dec  in  1  1 = decrypt, 0 = encrypt; sampled on accept.
- in_tag  in  TAG_W  passed through unchanged.
- rk_idx  out  4  round-key index requested this cycle.
- rk_data  in  128  round key for rk_idx, valid in the same cycle (combinational read).
- out_valid  out  1  result block present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result block.
- out_tag  out  TAG_W  tag of the result block.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: while rst is sampled high, FSM goes to IDLE, round counter is 0, state/out_data/out_tag are 0, and out_valid is 0. Reset mid-operation discards the block in flight; no partial output is produced.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, the block is accepted: state <= in_data ^ rk_data (round 0 AddRoundKey), dec/tag are latched, round <= 1, go to RUN.
  - RUN: in_ready = 0. Each cycle applies SubBytes, ShiftRows, MixColumns and AddRoundKey, using the inverse transforms when dec = 1. The round with round == NR skips MixColumns, its result loads out_data, and the FSM goes to DONE. Otherwise round increments.
  - DONE: out_valid = 1 and out_data/out_tag are held stable until out_ready.
    - out_ready with no in_valid: go to IDLE.
    - in_ready = out_ready. If out_ready && in_valid in the same cycle, the new block is accepted (round-0 ARK) and the FSM goes directly to RUN. This gives back-to-back operation with no bubble.
- Key index: rk_idx = r for encrypt, NR − r for decrypt, where r is the current round (0 in IDLE/DONE-accept cycles, using the live in_dec).
  - The key store supplies decryption keys 1..NR−1 already InvMixColumns-transformed; this engine never transforms keys.
- Latency: NR+1 clk edges from accept to out_valid (15 for AES-256). Throughput is one block per NR+1 cycles under continuous out_ready.
- in_data, in_dec and in_tag are don't-care when not accepted. out_data and out_tag are don't-care when out_valid = 0, but must not change while out_valid && !out_ready.
- Round counter is 4 bits; NR ≤ 14, so no wrap occurs.

Optional Feature:
- Macro AES_ROUND_ENGINE_CTR_EN.
- Defined:
  - Adds ports ctr_load (in, 1) and ctr_init (in, 128).
  - An internal 128-bit counter is loaded from ctr_init on ctr_load; ctr_load in the same cycle as an accept takes precedence for that block.
  - Each accepted block encrypts the counter (in_dec is ignored and forced to 0).
  - Output is E(ctr) ^ in_data, with in_data latched at accept.
  - The counter then increments its low 32 bits modulo 2^32, leaving the upper 96 bits unchanged.
- Undefined: ports are absent and the engine is a pure block cipher as above.

Decomposition:
- Package aes_pkg holds:
  - KEY_BITS→NR function;
  - block/word typedefs (128-bit block, 32-bit column, 8-bit byte);
  - FSM state enum (IDLE/RUN/DONE).
- Natural sub-module: aes_round_dp. It is the combinational round datapath: 16 SubBytes_mix, shift_rows_mix, 4 mix_columns_mix, a MixColumns bypass for the final round, and ARK. Inputs are state, key, inv and last.

Test Plan:
- AES-256 encrypt, key 000102…1f, pt 00112233445566778899aabbccddeeff -> out_data 8ea2b7ca516745bfeafc49904b496089 exactly 15 cycles after accept; decrypt of it returns pt.
- KEY_BITS=128 and 192 builds with FIPS-197 keys -> 69c4e0d86a7b0430d8cdb78070b4c55a (11 cycles) and dda97ca4864cdfe06eaf70a0ec0d7191 (13 cycles).
- Hold out_ready=0 for 5 cycles in DONE -> out_data/out_tag stable, in_ready=0; then out_ready=1 with in_valid=1 -> next block accepted same cycle, second result 15 cycles later; tags 3 and 4 return in order.
- rst pulse at round 7 -> next cycle out_valid=0, in_ready=1; subsequent FIPS vector completes correctly.
- Check rk_idx sequence: enc 0,1,…,14; dec 14,13,…,0.
- CTR_EN: ctr_init low word ffffffff, two blocks -> second counter has low word 00000000 with upper 96 bits unchanged; outputs equal E(ctr) ^ in_data.
